// File: rtl/mips_datapath_pc_sequencer_pkg.sv
// Shared types for the PC sequencer: clock/reset bundle, PC action codes,
// MIPS opcode/funct constants and the fetch FSM state encoding.
package mips_datapath_pc_sequencer_pkg;

  typedef struct packed {
    logic clock;
    logic reset;
  } ctrl_t;

  function automatic logic Clock(input ctrl_t c);
    return c.clock;
  endfunction

  function automatic logic Reset(input ctrl_t c);
    return c.reset;
  endfunction

  typedef enum logic [2:0] {
    PC_NONE   = 3'd0,
    PC_INC    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JUMP   = 3'd3,
    PC_JUMPR  = 3'd4
  } pc_action_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/mips_datapath_pc_sequencer_resolve.sv
// Combinational branch/jump resolution: maps the held instruction and the
// register operands to the PC action and its offset/target operands.
module mips_datapath_pc_sequencer_resolve
  import mips_datapath_pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 16,
  parameter int unsigned JUMP_W   = 26,
  parameter int unsigned INSTR_W  = 32
) (
  input  logic [INSTR_W-1:0]  instr,
  input  logic [31:0]         rsData,
  input  logic [31:0]         rtData,
  output pc_action_e          action,
  output logic [OFFSET_W-1:0] offset,
  output logic [JUMP_W-1:0]   jump,
  output logic [ADDR_W-1:0]   jumpr
);

  logic [5:0] op;
  logic [5:0] fn;

  always_comb begin
    op     = instr[31:26];
    fn     = instr[5:0];
    action = PC_INC;
    case (op)
      OP_J, OP_JAL: action = PC_JUMP;
      OP_SPECIAL:   if (fn == FN_JR || fn == FN_JALR) action = PC_JUMPR;
      OP_BEQ:       if (rsData == rtData) action = PC_BRANCH;
      OP_BNE:       if (rsData != rtData) action = PC_BRANCH;
      default:      action = PC_INC;
    endcase
  end

  assign offset = instr[OFFSET_W-1:0];
  assign jump   = instr[JUMP_W-1:0];
  assign jumpr  = ADDR_W'(rsData);

endmodule

// File: rtl/mips_datapath_pc_sequencer.sv
// Fetch sequencer between the PC unit and instruction memory (FETCH/WAIT/HOLD).
// Optional fetch timeout/reissue: define MIPS_DATAPATH_PC_SEQUENCER_TIMEOUT_EN.
module mips_datapath_pc_sequencer
  import mips_datapath_pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 16,
  parameter int unsigned JUMP_W   = 26,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned TIMEOUT  = 15
) (
  input  ctrl_t               ctrl,
  input  logic [ADDR_W-1:0]   addrCurr,
  output logic                memReqValid,
  input  logic                memReqReady,
  output logic [ADDR_W-1:0]   memReqAddr,
  input  logic                memRespValid,
  input  logic [INSTR_W-1:0]  memRespData,
  output logic [4:0]          rsAddr,
  output logic [4:0]          rtAddr,
  input  logic [31:0]         rsData,
  input  logic [31:0]         rtData,
  output logic                instrValid,
  input  logic                instrReady,
  output logic [INSTR_W-1:0]  instr,
  output pc_action_e          action,
  output logic [OFFSET_W-1:0] offset,
  output logic [JUMP_W-1:0]   jump,
  output logic [ADDR_W-1:0]   jumpr
);

  logic clk;
  logic rst;
  assign clk = Clock(ctrl);
  assign rst = Reset(ctrl);

  seq_state_e         state_q;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic               fire;
  logic               resp_take;
  logic               timeout;
  pc_action_e         resolved;

  // Request is gated by reset so it is low in every reset cycle, not just after the first edge.
  assign memReqValid = (state_q == S_FETCH) && !rst;
  assign memReqAddr  = addrCurr;
  assign instrValid  = instr_valid_q;
  assign instr       = instr_q;
  assign rsAddr      = instr_q[25:21];
  assign rtAddr      = instr_q[20:16];
  assign fire        = instr_valid_q && instrReady;
  assign action      = fire ? resolved : PC_NONE;

`ifdef MIPS_DATAPATH_PC_SEQUENCER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       stale_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             stale_rsp;
  logic             cnt_at_limit;

  // Late responses to abandoned fetches may land in any state; each one retires one stale slot.
  assign stale_rsp    = memRespValid && (stale_q != 2'd0);
  assign cnt_at_limit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign resp_take    = (state_q == S_WAIT) && memRespValid && (stale_q == 2'd0);
  assign timeout      = (state_q == S_WAIT) && !resp_take && cnt_at_limit && (stale_q != 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      stale_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      case ({timeout, stale_rsp})
        2'b10:   stale_q <= stale_q + 2'd1;
        2'b01:   stale_q <= stale_q - 2'd1;
        default: stale_q <= stale_q;
      endcase
      if (state_q == S_WAIT && !resp_take && !timeout) begin
        if (!cnt_at_limit) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end
`else
  assign resp_take = (state_q == S_WAIT) && memRespValid;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (memReqValid && memReqReady) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (resp_take) begin
            instr_q       <= memRespData;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end else if (timeout) begin
            state_q <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (fire) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  mips_datapath_pc_sequencer_resolve #(
    .ADDR_W   (ADDR_W),
    .OFFSET_W (OFFSET_W),
    .JUMP_W   (JUMP_W),
    .INSTR_W  (INSTR_W)
  ) u_resolve (
    .instr  (instr_q),
    .rsData (rsData),
    .rtData (rtData),
    .action (resolved),
    .offset (offset),
    .jump   (jump),
    .jumpr  (jumpr)
  );

endmodule

// File: tb/tb_mips_datapath_pc_sequencer.sv
// Directed bench for the PC sequencer; the bench plays the PC unit, memory and decode stage.
module tb_mips_datapath_pc_sequencer;
  import mips_datapath_pc_sequencer_pkg::*;

`ifdef MIPS_DATAPATH_PC_SEQUENCER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 15;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ctrl_t       ctrl;
  logic [31:0] addrCurr = 32'h0040_0000;
  logic        memReqValid;
  logic        memReqReady = 1'b0;
  logic [31:0] memReqAddr;
  logic        memRespValid = 1'b0;
  logic [31:0] memRespData = '0;
  logic [4:0]  rsAddr, rtAddr;
  logic [31:0] rsData = '0;
  logic [31:0] rtData = '0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instr;
  pc_action_e  action;
  logic [15:0] offset;
  logic [25:0] jump;
  logic [31:0] jumpr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] fire_off;
  logic [25:0] fire_jump;
  logic [31:0] fire_jumpr;
  logic [4:0]  fire_rs, fire_rt;

  assign ctrl = '{clock: clk, reset: rst};
  always #5 clk = ~clk;

  mips_datapath_pc_sequencer #(
    .ADDR_W   (32),
    .OFFSET_W (16),
    .JUMP_W   (26),
    .INSTR_W  (32),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .ctrl         (ctrl),
    .addrCurr     (addrCurr),
    .memReqValid  (memReqValid),
    .memReqReady  (memReqReady),
    .memReqAddr   (memReqAddr),
    .memRespValid (memRespValid),
    .memRespData  (memRespData),
    .rsAddr       (rsAddr),
    .rtAddr       (rtAddr),
    .rsData       (rsData),
    .rtData       (rtData),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .instr        (instr),
    .action       (action),
    .offset       (offset),
    .jump         (jump),
    .jumpr        (jumpr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // PC unit behaviour applied to the DUT's fire-cycle outputs.
  function automatic logic [31:0] pc_model(input logic [31:0] pc, input pc_action_e act,
                                           input logic [15:0] off, input logic [25:0] jmp,
                                           input logic [31:0] jr);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    case (act)
      PC_INC:    return pc4;
      PC_BRANCH: return pc4 + {{14{off[15]}}, off, 2'b00};
      PC_JUMP:   return {pc4[31:28], jmp, 2'b00};
      PC_JUMPR:  return jr;
      default:   return pc;
    endcase
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
  task automatic run_instr(input string tag, input logic [31:0] pc, input logic [31:0] word,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input int unsigned req_stall, input int unsigned hold_stall,
                           input pc_action_e exp_act, input logic [31:0] exp_next);
    logic [31:0] nxt;
    addrCurr = pc;
    #1;
    chk({tag, ".req_v"}, {31'd0, memReqValid}, 32'd1);
    chk({tag, ".req_addr"}, memReqAddr, pc);
    for (int unsigned i = 0; i < req_stall; i++) begin
      memRespValid = 1'b1;
      memRespData  = 32'hBAD0_0000 | i;
      @(negedge clk); #1;
      chk({tag, ".stall_req_v"}, {31'd0, memReqValid}, 32'd1);
      chk({tag, ".stall_req_addr"}, memReqAddr, pc);
      chk({tag, ".stall_req_act"}, {29'd0, action}, {29'd0, PC_NONE});
    end
    memRespValid = 1'b0;
    memReqReady  = 1'b1;
    @(negedge clk);
    memReqReady = 1'b0;
    #1;
    chk({tag, ".wait_req_v"}, {31'd0, memReqValid}, 32'd0);
    chk({tag, ".wait_ivalid"}, {31'd0, instrValid}, 32'd0);
    memRespValid = 1'b1;
    memRespData  = word;
    @(negedge clk);
    memRespValid = 1'b0;
    memRespData  = '0;
    rsData = rs;
    rtData = rt;
    #1;
    chk({tag, ".hold_ivalid"}, {31'd0, instrValid}, 32'd1);
    chk({tag, ".hold_instr"}, instr, word);
    chk({tag, ".hold_act"}, {29'd0, action}, {29'd0, PC_NONE});
    for (int unsigned i = 0; i < hold_stall; i++) begin
      memRespValid = 1'b1;
      memRespData  = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      chk({tag, ".stall_ivalid"}, {31'd0, instrValid}, 32'd1);
      chk({tag, ".stall_instr"}, instr, word);
      chk({tag, ".stall_act"}, {29'd0, action}, {29'd0, PC_NONE});
      chk({tag, ".stall_hold_req_v"}, {31'd0, memReqValid}, 32'd0);
    end
    memRespValid = 1'b0;
    instrReady   = 1'b1;
    #1;
    chk({tag, ".fire_act"}, {29'd0, action}, {29'd0, exp_act});
    fire_off   = offset;
    fire_jump  = jump;
    fire_jumpr = jumpr;
    fire_rs    = rsAddr;
    fire_rt    = rtAddr;
    nxt = pc_model(pc, action, offset, jump, jumpr);
    chk({tag, ".next_pc"}, nxt, exp_next);
    @(posedge clk); #1;
    addrCurr = nxt;
    @(negedge clk);
    instrReady = 1'b0;
    #1;
    chk({tag, ".post_act"}, {29'd0, action}, {29'd0, PC_NONE});
    chk({tag, ".post_ivalid"}, {31'd0, instrValid}, 32'd0);
    chk({tag, ".post_req_addr"}, memReqAddr, exp_next);
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst.req_v0", {31'd0, memReqValid}, 32'd0);
    @(negedge clk); #1;
    chk("rst.req_v1", {31'd0, memReqValid}, 32'd0);
    chk("rst.ivalid", {31'd0, instrValid}, 32'd0);
    chk("rst.instr", instr, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.after_req_v", {31'd0, memReqValid}, 32'd1);
    chk("rst.after_addr", memReqAddr, 32'h0040_0000);
    chk("rst.after_act", {29'd0, action}, {29'd0, PC_NONE});
    @(negedge clk);

    run_instr("add", 32'h0040_0000, 32'h0000_0020, 32'd0, 32'd0, 0, 0, PC_INC, 32'h0040_0004);
    run_instr("beq_t", 32'h0040_0000, 32'h1022_0003, 32'd7, 32'd7, 0, 0, PC_BRANCH, 32'h0040_0010);
    chk("beq_t.offset", {16'd0, fire_off}, 32'h0000_0003);
    chk("beq_t.rs_addr", {27'd0, fire_rs}, 32'd1);
    chk("beq_t.rt_addr", {27'd0, fire_rt}, 32'd2);
    run_instr("beq_n", 32'h0040_0000, 32'h1022_0003, 32'd7, 32'd8, 0, 0, PC_INC, 32'h0040_0004);
    run_instr("bne_t", 32'h0040_0000, 32'h1422_0003, 32'd7, 32'd8, 0, 0, PC_BRANCH, 32'h0040_0010);
    run_instr("bne_n", 32'h0040_0000, 32'h1422_0003, 32'd5, 32'd5, 0, 0, PC_INC, 32'h0040_0004);
    run_instr("beq_back", 32'h0040_0000, 32'h1000_FFFF, 32'd0, 32'd0, 0, 0, PC_BRANCH, 32'h0040_0000);
    run_instr("j", 32'h0040_0000, 32'h0810_0000, 32'd0, 32'd0, 0, 0, PC_JUMP, 32'h0040_0000);
    chk("j.jump", {6'd0, fire_jump}, 32'h0010_0000);
    run_instr("jal", 32'h0040_0000, 32'h0C10_0010, 32'd0, 32'd0, 0, 0, PC_JUMP, 32'h0040_0040);
    run_instr("jr", 32'h0040_0000, 32'h03E0_0008, 32'h0040_0100, 32'd0, 0, 0, PC_JUMPR, 32'h0040_0100);
    chk("jr.jumpr", fire_jumpr, 32'h0040_0100);
    chk("jr.rs_addr", {27'd0, fire_rs}, 32'd31);
    run_instr("jalr", 32'h0040_0000, 32'h0060_F809, 32'h0040_0200, 32'd0, 0, 0, PC_JUMPR, 32'h0040_0200);
    run_instr("bp", 32'h0040_0020, 32'h0000_0020, 32'd0, 32'd0, 4, 5, PC_INC, 32'h0040_0024);

    // Reset while an instruction is held drops it.
    addrCurr    = 32'h0040_0000;
    memReqReady = 1'b1;
    @(negedge clk);
    memReqReady  = 1'b0;
    memRespValid = 1'b1;
    memRespData  = 32'h0000_1234;
    @(negedge clk);
    memRespValid = 1'b0;
    #1;
    chk("mid_rst.held", {31'd0, instrValid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst.req_v", {31'd0, memReqValid}, 32'd0);
    @(negedge clk); #1;
    chk("mid_rst.ivalid", {31'd0, instrValid}, 32'd0);
    chk("mid_rst.instr", instr, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst.after_req_v", {31'd0, memReqValid}, 32'd1);
    @(negedge clk);

`ifdef MIPS_DATAPATH_PC_SEQUENCER_TIMEOUT_EN
    addrCurr    = 32'h0040_0080;
    memReqReady = 1'b1;
    @(negedge clk);
    memReqReady = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      chk("to.wait_req_v", {31'd0, memReqValid}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("to.reissue_v", {31'd0, memReqValid}, 32'd1);
    chk("to.reissue_addr", memReqAddr, 32'h0040_0080);
    memReqReady = 1'b1;
    @(negedge clk);
    memReqReady  = 1'b0;
    memRespValid = 1'b1;
    memRespData  = 32'hDEAD_0001;
    @(negedge clk);
    memRespData = 32'h0000_0020;
    #1;
    chk("to.stale_dropped", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    memRespValid = 1'b0;
    #1;
    chk("to.second_valid", {31'd0, instrValid}, 32'd1);
    chk("to.second_instr", instr, 32'h0000_0020);
    instrReady = 1'b1;
    #1;
    chk("to.fire_act", {29'd0, action}, {29'd0, PC_INC});
    @(negedge clk);
    instrReady = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
